// File: rtl/controle_fechadura.sv
// controle_fechadura: door-lock FSM (idle/open/lockout) with wrong-attempt counting and a shared hold timer
module controle_fechadura #(
  parameter int T_ABERTA   = 50_000_000,
  parameter int T_BLOQUEIO = 250_000_000,
  parameter int MAX_TENT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       senha_correta,
  input  logic       senha_errada,
  output logic       porta_aberta,
  output logic       bloqueado,
  output logic       alarme,
  output logic [1:0] tentativas,
  output logic [1:0] estado
);
  typedef enum logic [1:0] {OCIOSO = 2'b00, ABERTA = 2'b01, BLOQUEADO = 2'b10} estado_t;
  localparam int TMAX = (T_ABERTA > T_BLOQUEIO) ? T_ABERTA : T_BLOQUEIO;
  localparam int TW = $clog2(TMAX + 1);
  estado_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic porta_q, porta_d, bloq_q, bloq_d, alarme_q, alarme_d;
  logic [1:0] tent_q, tent_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= OCIOSO;
      timer_q  <= '0;
      porta_q  <= 1'b0;
      bloq_q   <= 1'b0;
      alarme_q <= 1'b0;
      tent_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      porta_q  <= porta_d;
      bloq_q   <= bloq_d;
      alarme_q <= alarme_d;
      tent_q   <= tent_d;
    end
  // timer is loaded with hold-1 and the exit happens on the edge that sees zero,
  // so the output stays high for exactly the hold length
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    porta_d  = 1'b0;
    bloq_d   = 1'b0;
    alarme_d = 1'b0;
    tent_d   = 2'd0;
    case (state_q)
      OCIOSO: begin
        tent_d = tent_q;
        if (senha_errada) begin
          if ({1'b0, tent_q} + 3'd1 == 3'(MAX_TENT)) begin
            state_d  = BLOQUEADO;
            bloq_d   = 1'b1;
            alarme_d = 1'b1;
            tent_d   = 2'd0;
            timer_d  = TW'(T_BLOQUEIO - 1);
          end else tent_d = tent_q + 2'd1;
        end else if (senha_correta) begin
          state_d = ABERTA;
          porta_d = 1'b1;
          tent_d  = 2'd0;
          timer_d = TW'(T_ABERTA - 1);
        end
      end
      ABERTA: begin
        state_d = (timer_q == '0) ? OCIOSO : ABERTA;
        porta_d = (timer_q != '0);
        timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
      end
      BLOQUEADO: begin
        state_d = (timer_q == '0) ? OCIOSO : BLOQUEADO;
        bloq_d  = (timer_q != '0);
        timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
      end
      default: begin
        state_d = OCIOSO;
        timer_d = '0;
      end
    endcase
  end
  assign porta_aberta = porta_q;
  assign bloqueado    = bloq_q;
  assign alarme       = alarme_q;
  assign tentativas   = tent_q;
  assign estado       = state_q;
endmodule

// File: tb/tb_controle_fechadura.sv
// tb_controle_fechadura: randomized scoreboard bench for controle_fechadura against an absolute-time event model
module tb_controle_fechadura;
  localparam int TA = 4, TB = 8, MT = 3;
  logic clk = 1'b0, rst_n = 1'b0, sc = 1'b0, se = 1'b0;
  logic porta, bloq, alarme;
  logic [1:0] tent, estado;
  typedef struct packed {logic p; logic b; logic a; logic [1:0] t; logic [1:0] s;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int e = 0, open_end = 0, lock_end = 0, alarm_at = -1, wrongs = 0;
  controle_fechadura #(.T_ABERTA(TA), .T_BLOQUEIO(TB), .MAX_TENT(MT)) dut (
    .clk(clk), .rst_n(rst_n), .senha_correta(sc), .senha_errada(se),
    .porta_aberta(porta), .bloqueado(bloq), .alarme(alarme), .tentativas(tent), .estado(estado));
  always #5 clk = ~clk;
  function automatic exp_t model_step(input logic c, input logic w);
    exp_t x;
    e++;
    if (e > open_end && e > lock_end) begin
      if (w) begin
        wrongs++;
        if (wrongs == MT) begin
          lock_end = e + TB;
          alarm_at = e;
          wrongs = 0;
        end
      end else if (c) begin
        open_end = e + TA;
        wrongs = 0;
      end
    end
    x.p = (e < open_end);
    x.b = (e < lock_end);
    x.a = (e == alarm_at);
    x.t = 2'(wrongs);
    x.s = x.p ? 2'b01 : x.b ? 2'b10 : 2'b00;
    return x;
  endfunction
  task automatic cmp(input string name, input exp_t x);
    exp_t a;
    a = {porta, bloq, alarme, tent, estado};
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s t=%0t got p=%b b=%b a=%b t=%0d s=%b expected p=%b b=%b a=%b t=%0d s=%b",
               name, $time, a.p, a.b, a.a, a.t, a.s, x.p, x.b, x.a, x.t, x.s);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) cmp("cycle", q.pop_front());
  end
  task automatic async_reset(input string name);
    sc = 1'b0;
    se = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 cmp(name, '0);
    open_end = e;
    lock_end = e;
    wrongs = 0;
    alarm_at = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int locked_resets = 0;
    #1 cmp("reset_init", '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0 && $urandom_range(0, 199) == 0) async_reset("reset_rand");
      else if (e < lock_end && e > lock_end - TB + 2 && locked_resets < 5 && $urandom_range(0, 3) == 0) begin
        locked_resets++;
        async_reset("reset_lock");
      end
      sc = ($urandom_range(0, 7) == 0);
      se = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        sc = 1'b1;
        se = 1'b1;
      end
      q.push_back(model_step(sc, se));
      @(negedge clk);
    end
    sc = 1'b0;
    se = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
